// File: rtl/xcache_resp_v1_if.sv
// ---------------------------------------------------------------------------
// xcache_resp_v1_if
// Request/response bundle for the single-master XCACHE memory interface.
//   mem_part   : partition select (master -> responder)
//   mem_re     : read request
//   mem_we     : byte write enables, a write when non-zero
//   mem_ad     : byte address
//   mem_di     : write data
//   mem_rdy    : responder accepts a request this cycle
//   mem_do     : read data, qualified by mem_do_vld
//   mem_do_vld : one-cycle pulse per returned read
// ---------------------------------------------------------------------------
interface xcache_resp_v1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            mem_part;
    logic                  mem_re;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_ad;
    logic [DATA_WIDTH-1:0] mem_di;
    logic                  mem_rdy;
    logic [DATA_WIDTH-1:0] mem_do;
    logic                  mem_do_vld;

    modport master (
        output mem_part, mem_re, mem_we, mem_ad, mem_di,
        input  mem_rdy, mem_do, mem_do_vld
    );

    modport slave (
        input  mem_part, mem_re, mem_we, mem_ad, mem_di,
        output mem_rdy, mem_do, mem_do_vld
    );
endinterface

// File: rtl/xcache_resp_v1.sv
// ---------------------------------------------------------------------------
// xcache_resp_v1
// Memory-side responder / end model for the XCACHE request interface.
// Accepts one read or write per cycle and returns read data in order after a
// fixed latency of RD_LAT cycles, from a PART_NUM x DEPTH word array.
//   clk       : clock
//   rstn      : asynchronous active-low reset
//   hold      : blocks acceptance (miss-stall emulation); in-flight reads drain
//   mem       : request/response bundle (slave side)
//   err_oob   : sticky, an accepted request addressed a partition >= PART_NUM
//   outst_cnt : reads accepted but not yet returned
// ---------------------------------------------------------------------------
module xcache_resp_v1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PART_NUM   = 4,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 2,
    parameter int MAX_OUTST  = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             hold,
    xcache_resp_v1_if.slave                  mem,
    output logic                             err_oob,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (PART_NUM > 1) ? $clog2(PART_NUM) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [DATA_WIDTH-1:0] mem_q [PART_NUM][DEPTH];

    logic                  rdy;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  part_ok;
    logic [PW-1:0]         pidx;
    logic [IW-1:0]         widx;
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [RD_LAT-1:0]     pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_dat [RD_LAT];

    // Byte offset and address bits above the word index are don't-care.
    logic unused_bits;
    assign unused_bits = ^{mem.mem_ad[1:0], mem.mem_ad[ADDR_WIDTH-1:2+IW]};

    // A slot only frees once the count register has dropped, so a response
    // leaving this cycle does not raise mem_rdy until the next one.
    assign rdy     = ~hold & (outst_cnt < OW'(MAX_OUTST));
    assign rd_acc  = mem.mem_re & rdy;
    assign wr_acc  = (|mem.mem_we) & rdy;
    assign part_ok = (mem.mem_part < 8'(PART_NUM));
    assign pidx    = mem.mem_part[PW-1:0];
    assign widx    = mem.mem_ad[2 +: IW];

    // Read returns the merged post-write word so a combined re+we request
    // sees its own write; out-of-range partitions read as zero.
    always_comb begin
        rd_raw  = '0;
        rd_data = '0;
        if (part_ok) begin
            rd_raw = mem_q[pidx][widx];
            for (int b = 0; b < 4; b++) begin
                rd_data[8*b +: 8] = mem.mem_we[b] ? mem.mem_di[8*b +: 8]
                                                  : rd_raw[8*b +: 8];
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc && part_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.mem_we[b]) begin
                    mem_q[pidx][widx][8*b +: 8] <= mem.mem_di[8*b +: 8];
                end
            end
        end
    end

    // Data registers only load with a valid so the last stage (mem_do) holds
    // its previous value between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst_cnt <= '0;
            err_oob   <= 1'b0;
        end else begin
            if (rd_acc && !pipe_vld[RD_LAT-1]) begin
                outst_cnt <= outst_cnt + 1'b1;
            end else if (!rd_acc && pipe_vld[RD_LAT-1]) begin
                outst_cnt <= outst_cnt - 1'b1;
            end
            if ((rd_acc || wr_acc) && !part_ok) begin
                err_oob <= 1'b1;
            end
        end
    end

    assign mem.mem_rdy    = rdy;
    assign mem.mem_do     = pipe_dat[RD_LAT-1];
    assign mem.mem_do_vld = pipe_vld[RD_LAT-1];

endmodule

// File: tb/tb_xcache_resp_v1.sv
// ---------------------------------------------------------------------------
// tb_xcache_resp_v1
// Directed bench for xcache_resp_v1 (RD_LAT=2, MAX_OUTST=2, PART_NUM=4).
// Each table row is one clock cycle: inputs driven just after the rising
// edge, outputs compared on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_xcache_resp_v1;
    logic       clk;
    logic       rstn;
    logic       hold;
    logic       err_oob;
    logic [1:0] outst_cnt;

    xcache_resp_v1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    xcache_resp_v1 #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PART_NUM(4),
        .DEPTH(256), .RD_LAT(2), .MAX_OUTST(2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .hold      (hold),
        .mem       (bus),
        .err_oob   (err_oob),
        .outst_cnt (outst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic [7:0]  part;
        logic        re;
        logic [3:0]  we;
        logic [31:0] ad;
        logic [31:0] di;
        logic        rdy;
        logic        vld;
        logic [31:0] dout;
        logic [1:0]  oc;
        logic        err;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic h, input logic [7:0] p, input logic re,
                                input logic [3:0] we, input logic [31:0] ad,
                                input logic [31:0] di, input logic rdy,
                                input logic vld, input logic [31:0] dout,
                                input logic [1:0] oc, input logic err);
        mk = '{h, p, re, we, ad, di, rdy, vld, dout, oc, err};
    endfunction

    function automatic vec_t idle(input logic rdy, input logic vld,
                                  input logic [31:0] dout, input logic [1:0] oc);
        idle = mk(0, 8'd0, 0, 4'h0, 32'h0, 32'h0, rdy, vld, dout, oc, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [7:0] p, input logic re,
                         input logic [3:0] we, input logic [31:0] ad, input logic [31:0] di);
        hold         = h;
        bus.mem_part = p;
        bus.mem_re   = re;
        bus.mem_we   = we;
        bus.mem_ad   = ad;
        bus.mem_di   = di;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int vld_seen;
    logic [31:0] vld_dat [2];

    initial begin
        // Test 1: write then read back
        tbl[0]  = idle(1, 0, 32'h0, 0);
        tbl[1]  = mk(0, 8'd1, 0, 4'hF, 32'h10, 32'hA5A5_1234, 1, 0, 32'h0, 0, 0);
        tbl[2]  = mk(0, 8'd1, 1, 4'h0, 32'h10, 32'h0,         1, 0, 32'h0, 0, 0);
        tbl[3]  = idle(1, 0, 32'h0, 1);
        tbl[4]  = idle(1, 1, 32'hA5A5_1234, 1);
        tbl[5]  = idle(1, 0, 32'h0, 0);
        // Test 2: byte enables and combined read+write
        tbl[6]  = mk(0, 8'd0, 0, 4'hF, 32'h20, 32'h1122_3344, 1, 0, 32'h0, 0, 0);
        tbl[7]  = mk(0, 8'd0, 0, 4'h5, 32'h20, 32'hAABB_CCDD, 1, 0, 32'h0, 0, 0);
        tbl[8]  = mk(0, 8'd0, 1, 4'h0, 32'h20, 32'h0,         1, 0, 32'h0, 0, 0);
        tbl[9]  = mk(0, 8'd0, 1, 4'h8, 32'h20, 32'hFF00_0000, 1, 0, 32'h0, 1, 0);
        tbl[10] = idle(0, 1, 32'h11BB_33DD, 2);
        tbl[11] = idle(1, 1, 32'hFFBB_33DD, 1);
        tbl[12] = mk(0, 8'd0, 1, 4'h0, 32'h20, 32'h0,         1, 0, 32'h0, 0, 0);
        tbl[13] = idle(1, 0, 32'h0, 1);
        tbl[14] = idle(1, 1, 32'hFFBB_33DD, 1);
        tbl[15] = idle(1, 0, 32'h0, 0);
        // Test 3: outstanding cap with mem_re held; 0x408 wraps onto index 2
        tbl[16] = mk(0, 8'd2, 0, 4'hF, 32'h000, 32'h100, 1, 0, 32'h0, 0, 0);
        tbl[17] = mk(0, 8'd2, 0, 4'hF, 32'h004, 32'h101, 1, 0, 32'h0, 0, 0);
        tbl[18] = mk(0, 8'd2, 0, 4'hF, 32'h408, 32'h102, 1, 0, 32'h0, 0, 0);
        tbl[19] = mk(0, 8'd2, 1, 4'h0, 32'h000, 32'h0,   1, 0, 32'h0, 0, 0);
        tbl[20] = mk(0, 8'd2, 1, 4'h0, 32'h004, 32'h0,   1, 0, 32'h0, 1, 0);
        tbl[21] = mk(0, 8'd2, 1, 4'h0, 32'h008, 32'h0,   0, 1, 32'h100, 2, 0);
        tbl[22] = mk(0, 8'd2, 1, 4'h0, 32'h008, 32'h0,   1, 1, 32'h101, 1, 0);
        tbl[23] = idle(1, 0, 32'h0, 1);
        tbl[24] = idle(1, 1, 32'h102, 1);
        tbl[25] = idle(1, 0, 32'h0, 0);

        rstn = 1'b0;
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(bus.mem_do_vld), 32'h0);
        chk("rst_do",  bus.mem_do, 32'h0);
        chk("rst_err", 32'(err_oob), 32'h0);
        chk("rst_oc",  32'(outst_cnt), 32'h0);
        next_cycle();
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].hold, tbl[i].part, tbl[i].re, tbl[i].we, tbl[i].ad, tbl[i].di);
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(bus.mem_rdy),    32'(tbl[i].rdy));
            chk($sformatf("v%0d_vld", i), 32'(bus.mem_do_vld), 32'(tbl[i].vld));
            if (tbl[i].vld)
                chk($sformatf("v%0d_do", i), bus.mem_do, tbl[i].dout);
            chk($sformatf("v%0d_oc", i),  32'(outst_cnt), 32'(tbl[i].oc));
            chk($sformatf("v%0d_err", i), 32'(err_oob),   32'(tbl[i].err));
            next_cycle();
        end

        // Test 4: hold with two reads in flight
        drive(0, 8'd2, 1, 4'h0, 32'h0, 32'h0);
        next_cycle();
        drive(0, 8'd2, 1, 4'h0, 32'h4, 32'h0);
        next_cycle();
        vld_seen = 0;
        vld_dat[0] = '0;
        vld_dat[1] = '0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'd2, 1, 4'h0, 32'h8, 32'h0);
            @(negedge clk);
            chk($sformatf("hold%0d_rdy", c), 32'(bus.mem_rdy), 32'h0);
            if (bus.mem_do_vld) begin
                if (vld_seen < 2) vld_dat[vld_seen] = bus.mem_do;
                vld_seen++;
            end
            next_cycle();
        end
        chk("hold_pulses", 32'(vld_seen), 32'd2);
        chk("hold_d0", vld_dat[0], 32'h100);
        chk("hold_d1", vld_dat[1], 32'h101);
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("unhold_rdy", 32'(bus.mem_rdy), 32'h1);
        chk("unhold_oc",  32'(outst_cnt), 32'h0);
        chk("unhold_vld", 32'(bus.mem_do_vld), 32'h0);
        next_cycle();

        // Test 5: out-of-range partition
        drive(0, 8'd0, 0, 4'hF, 32'h30, 32'hCAFE_F00D);
        @(negedge clk);
        chk("oob_err_pre", 32'(err_oob), 32'h0);
        next_cycle();
        drive(0, 8'd4, 0, 4'hF, 32'h30, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("oob_err_wr", 32'(err_oob), 32'h0);
        next_cycle();
        drive(0, 8'd4, 1, 4'h0, 32'h30, 32'h0);
        @(negedge clk);
        chk("oob_err_set", 32'(err_oob), 32'h1);
        next_cycle();
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("oob_vld", 32'(bus.mem_do_vld), 32'h1);
        chk("oob_do",  bus.mem_do, 32'h0);
        next_cycle();
        drive(0, 8'd0, 1, 4'h0, 32'h30, 32'h0);
        next_cycle();
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("p0_vld", 32'(bus.mem_do_vld), 32'h1);
        chk("p0_do",  bus.mem_do, 32'hCAFE_F00D);
        chk("oob_sticky", 32'(err_oob), 32'h1);
        next_cycle();

        // Test 6: reset with reads in flight
        drive(0, 8'd1, 1, 4'h0, 32'h10, 32'h0);
        next_cycle();
        drive(0, 8'd0, 1, 4'h0, 32'h20, 32'h0);
        next_cycle();
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("rst2_vld", 32'(bus.mem_do_vld), 32'h0);
        chk("rst2_do",  bus.mem_do, 32'h0);
        chk("rst2_err", 32'(err_oob), 32'h0);
        chk("rst2_oc",  32'(outst_cnt), 32'h0);
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_vld", c), 32'(bus.mem_do_vld), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("post_rst_oc",  32'(outst_cnt), 32'h0);
        chk("post_rst_rdy", 32'(bus.mem_rdy), 32'h1);
        next_cycle();
        drive(0, 8'd1, 1, 4'h0, 32'h10, 32'h0);
        next_cycle();
        drive(0, 8'd0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("keep_vld", 32'(bus.mem_do_vld), 32'h1);
        chk("keep_do",  bus.mem_do, 32'hA5A5_1234);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000");
        $fatal(1);
    end
endmodule

// File: doc/xcache_resp_v1.md
Name: xcache_resp_v1

Overview:
- Memory-side responder for the single-master XCACHE request interface: accepts one read or write per cycle on the mem_* handshake and returns read data in order after a fixed latency.
- Backed by a partitioned local word array of PART_NUM x DEPTH words.
- Serves as the XCACHE end model and bring-up target behind the RISC-V arbitration bus; also usable as a small scratchpad.
- Supports multiple outstanding reads, capped by MAX_OUTST, plus an external hold input that emulates miss stalls.

Parameters:
- ADDR_WIDTH, 32, byte address width of mem_ad.
- DATA_WIDTH, 32, data width. Fixed at 32 with 4 byte-enables.
- PART_NUM, 4, number of partitions. Valid mem_part values are 0..PART_NUM-1.
- DEPTH, 256, words per partition. Must be a power of 2 and >= 2.
- RD_LAT, 2, accept-to-mem_do_vld latency in cycles. Range 1..8.
- MAX_OUTST, 2, maximum reads in flight. Range 1..RD_LAT.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- hold  in  1  when 1, forces mem_rdy=0; in-flight reads still complete
- mem_part  in  8  partition select
- mem_re  in  1  read request
- mem_we  in  4  byte write enables; a request is a write when mem_we != 0
- mem_ad  in  ADDR_WIDTH  byte address; word index = mem_ad[2 +: log2(DEPTH)]
- mem_di  in  DATA_WIDTH  write data
- mem_rdy  out  1  request accepted this cycle when (mem_re | (mem_we!=0)) & mem_rdy
- mem_do  out  DATA_WIDTH  read data, valid only with mem_do_vld
- mem_do_vld  out  1  one-cycle pulse per accepted read, in acceptance order
- err_oob  out  1  sticky flag: an accepted request had mem_part >= PART_NUM
- outst_cnt  out  $clog2(MAX_OUTST+1)  reads accepted but not yet returned (debug)

Behaviour:
- Reset (async, rstn=0):
  - mem_do_vld=0, mem_do=0, err_oob=0, outst_cnt=0.
  - Pipeline valid bits are cleared.
  - Array contents are not reset.
  - Reads in flight when reset asserts are discarded and never returned.
- mem_rdy is combinational: mem_rdy = ~hold & (outst_cnt < MAX_OUTST).
  - It does not depend on mem_re/mem_we.
  - A response leaving in the same cycle does not free a slot that cycle.
- Write, on acceptance with mem_we != 0: for each b with mem_we[b]=1, word[part][idx][8b+7:8b] <= mem_di[8b+7:8b] at that clock edge. Bytes with enable 0 are unchanged.
- Read, on acceptance with mem_re=1:
  - The array is read in the accept cycle.
  - The data enters stage 1 of an RD_LAT-deep valid+data shift pipeline.
  - mem_do_vld=1 exactly RD_LAT cycles after the accept edge, carrying that data. mem_do holds its last value when mem_do_vld=0.
- mem_re=1 and mem_we!=0 in the same accepted cycle:
  - The write is committed.
  - The read returns the merged post-write word: enabled bytes from mem_di, other bytes from the array.
  - This counts as one outstanding read.
- Read-after-write: a read accepted the cycle after a write to the same word returns the written data. No hazard window.
- Ordering: strictly in order, because latency is fixed. There is no response backpressure; the master must sink mem_do_vld.
- outst_cnt update:
  - +1 on an accepted read.
  - -1 on mem_do_vld.
  - Unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTST, which is guaranteed by mem_rdy.
- Out-of-range partition (mem_part >= PART_NUM) on an accepted request:
  - The write is dropped.
  - A read still returns a response, with data 0, at the normal latency.
  - err_oob is set to 1 and stays 1 until reset.
- Upper address bits above the word index are ignored and wrap modulo DEPTH. Bits mem_ad[1:0] are ignored.
- hold asserted:
  - Affects acceptance only.
  - The pipeline keeps shifting and outst_cnt drains to 0.
  - Deasserting hold restores mem_rdy in the same cycle, subject to the outst_cnt condition.
- Idle cycles (no request) leave all state unchanged except pipeline advance.

Test Plan:
1. Reset release with RD_LAT=2, MAX_OUTST=2; write part=1, ad=0x10, we=4'hF, di=0xA5A5_1234; read same in the next cycle -> mem_do_vld exactly 2 cycles after the read accept, mem_do=0xA5A5_1234; all outputs 0 during reset.
2. Byte enables: word preloaded with 0x1122_3344; write we=4'b0101, di=0xAABB_CCDD; read back -> 0x11BB_33DD. Simultaneous re + we=4'b1000, di=0xFF00_0000 -> 0xFFBB_33DD.
3. Back-to-back reads to 3 distinct addresses with mem_re held -> mem_rdy drops after 2 accepts (outst_cnt=2); the 3rd read is accepted once the first response has returned (outst_cnt<2); 3 responses arrive in order with correct data.
4. hold=1 for 5 cycles with 2 reads in flight -> mem_rdy=0 throughout, both mem_do_vld pulses still appear, outst_cnt reaches 0; hold=0 -> mem_rdy=1 in the same cycle.
5. Read and write with mem_part=4 (PART_NUM=4) -> read returns 0 at normal latency, err_oob=1 and stays set; the partition 0 word at the same index is unchanged.
6. Assert rstn=0 while 2 reads are in flight -> no mem_do_vld after reset release, outst_cnt=0, mem_rdy=1; array data previously written is still readable.
